// File: rtl/reset_button_conditioner.sv
// reset_button_conditioner
//
// Turns the raw board reset push-button into a clean, glitch-free,
// minimum-width active-high reset for the downstream core. The block
// synchronises the external reset and the button, debounces the button with
// a cycle counter, and stretches the resulting reset with a small FSM.
//
// Parameters
//   DEBOUNCE_CYCLES    consecutive stable cycles needed to accept a new button level (>= 1)
//   RESET_HOLD_CYCLES  cycles reset_out stays high after release / reset deassertion (>= 1)
//   BUTTON_ACTIVE_HIGH 1: pin reads 1 when pressed; 0: pin is inverted at the input
//
// Ports
//   clock        single clock domain
//   reset        asynchronous active-high reset (e.g. PLL not locked)
//   button       raw, asynchronous, bouncing push-button pin
//   reset_out    conditioned active-high reset for the core
//   press_event  one-cycle pulse for each accepted press
//   o_dbg_state  current FSM state (0 = HOLD, 1 = RUN, 2 = PRESSED)
module reset_button_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 120000,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int BUTTON_ACTIVE_HIGH = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    output logic       reset_out,
    output logic       press_event,
    output logic [1:0] o_dbg_state
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        PRESSED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchroniser: asserts immediately, releases on the second
    // clock edge after reset falls. r_rst_s2 is the internal reset.
    // ------------------------------------------------------------------
    logic r_rst_s1;
    logic r_rst_s2;
    logic w_rst_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rst_s1 <= 1'b1;
            r_rst_s2 <= 1'b1;
        end else begin
            r_rst_s1 <= 1'b0;
            r_rst_s2 <= r_rst_s1;
        end
    end

    assign w_rst_i = r_rst_s2;

    // ------------------------------------------------------------------
    // Button synchroniser. Polarity is normalised before the first flop
    // so everything downstream treats 1 as "pressed".
    // ------------------------------------------------------------------
    logic w_btn_in;
    logic r_btn_s1;
    logic r_btn_s2;

    assign w_btn_in = button ^ (BUTTON_ACTIVE_HIGH == 0);

    always_ff @(posedge clock or posedge w_rst_i) begin
        if (w_rst_i) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_btn_s1 <= w_btn_in;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: counts consecutive cycles in which the synchronised level
    // differs from the accepted one. Any agreement restarts the count, and
    // the count is cleared on acceptance, so it never wraps.
    // ------------------------------------------------------------------
    logic            r_btn_db;
    logic [DB_W-1:0] r_db_cnt;

    always_ff @(posedge clock or posedge w_rst_i) begin
        if (w_rst_i) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_btn_s2 == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_btn_s2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stretch FSM. HOLD keeps the core in reset for RESET_HOLD_CYCLES after
    // every entry; a debounced press wins over hold expiry. press_event is
    // registered together with the transition into PRESSED.
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press_event;

    always_ff @(posedge clock or posedge w_rst_i) begin
        if (w_rst_i) begin
            r_state       <= HOLD;
            r_hold_cnt    <= '0;
            r_press_event <= 1'b0;
        end else begin
            r_press_event <= 1'b0;
            case (r_state)
                HOLD: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    if (r_btn_db) begin
                        r_state       <= PRESSED;
                        r_press_event <= 1'b1;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_btn_db) begin
                        r_state       <= PRESSED;
                        r_press_event <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!r_btn_db) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= HOLD;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    // Decoded from registers only; r_rst_s2 makes it assert with no clock.
    assign reset_out   = (r_state != RUN) | r_rst_s2;
    assign press_event = r_press_event;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Bench for reset_button_conditioner. Two instances share the clock, reset
// and button: dut0 (D=8, H=4, active-high pin) and dut1 (D=1, H=3,
// active-low pin). A behavioural model predicts both each cycle; the
// expected tuple is queued at stimulus time and a negedge monitor pops it.
module tb_reset_button_conditioner;

  localparam int D0 = 8;
  localparam int H0 = 4;
  localparam int D1 = 1;
  localparam int H1 = 3;
  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic button = 1'b0;
  logic button_n;
  logic ro0, pe0, ro1, pe1;
  logic [1:0] st0, st1;

  assign button_n = ~button;

  always #5 clock = ~clock;

  reset_button_conditioner #(
    .DEBOUNCE_CYCLES(D0), .RESET_HOLD_CYCLES(H0), .BUTTON_ACTIVE_HIGH(1)
  ) dut0 (
    .clock(clock), .reset(reset), .button(button),
    .reset_out(ro0), .press_event(pe0), .o_dbg_state(st0)
  );

  reset_button_conditioner #(
    .DEBOUNCE_CYCLES(D1), .RESET_HOLD_CYCLES(H1), .BUTTON_ACTIVE_HIGH(0)
  ) dut1 (
    .clock(clock), .reset(reset), .button(button_n),
    .reset_out(ro1), .press_event(pe1), .o_dbg_state(st1)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // low_cnt: consecutive edges that sampled reset low. Edges 1 and 2 of a
  // release are still inside the synchroniser; from the 3rd on logic runs.
  int   low_cnt = 0;
  int   act = 0;       // active edges since last reset
  int   edge_n = 0;    // global edge counter
  logic pin_h[64];     // pin sampled at active edge k (k mod 64)
  logic bs_h[64];      // synchronised level seen at active edge k
  logic m_db[2];       // accepted (debounced) level
  logic m_pr[2];       // pressed state
  logic m_pe[2];       // press pulse
  int   m_entry[2];    // edge at which the hold period last started
  int   m_d[2];
  int   m_h[2];

  task automatic m_clear();
    act = 0;
    for (int i = 0; i < 2; i++) begin
      m_db[i] = 1'b0;
      m_pr[i] = 1'b0;
      m_pe[i] = 1'b0;
    end
  endtask

  task automatic m_async_reset();
    low_cnt = 0;
    m_clear();
  endtask

  task automatic m_edge();
    logic bs, was, all_diff;
    edge_n++;
    if (reset) low_cnt = 0;
    else if (low_cnt < 1000) low_cnt++;
    if (low_cnt < 3) begin
      m_clear();
      for (int i = 0; i < 2; i++) m_entry[i] = edge_n;
    end else begin
      // The synchronised level lags the pin by two active edges.
      bs = (act >= 2) ? pin_h[(act - 2) % 64] : 1'b0;
      bs_h[act % 64] = bs;
      pin_h[act % 64] = button;
      act++;
      for (int i = 0; i < 2; i++) begin
        was = m_pr[i];
        m_pr[i] = m_db[i];
        m_pe[i] = m_pr[i] && !was;
        if (was && !m_pr[i]) m_entry[i] = edge_n;
        // A new level is accepted once the last D observations all disagree.
        if (act >= m_d[i]) begin
          all_diff = 1'b1;
          for (int k = 0; k < m_d[i]; k++)
            if (bs_h[(act - 1 - k) % 64] == m_db[i]) all_diff = 1'b0;
          if (all_diff) m_db[i] = ~m_db[i];
        end
      end
    end
  endtask

  function automatic logic [3:0] m_exp(input int i);
    logic [1:0] st;
    logic ro, pe;
    if (low_cnt < 3) st = S_HOLD;
    else if (m_pr[i]) st = S_PRESSED;
    else if (edge_n - m_entry[i] >= m_h[i]) st = S_RUN;
    else st = S_HOLD;
    ro = (low_cnt < 2) || (st != S_RUN);
    pe = (low_cnt >= 3) && m_pe[i];
    return {st, ro, pe};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1: apply inputs, queue the prediction for this cycle,
  // then advance one clock edge.
  task automatic step(input logic b, input logic r);
    button = b;
    reset = r;
    if (r) m_async_reset();
    exp_q.push_back({m_exp(1), m_exp(0)});
    @(posedge clock);
    m_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    n_vec++;
    if (act_v != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin : monitor
    logic [7:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {st1, ro1, pe1, st0, ro0, pe0};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL scoreboard t=%0t got dut1(st,ro,pe)=%0d,%b,%b dut0=%0d,%b,%b expected dut1=%0d,%b,%b dut0=%0d,%b,%b",
                 $time, st1, ro1, pe1, st0, ro0, pe0,
                 e[7:6], e[5], e[4], e[3:2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rise, fall, pe_cnt, bad, k;
    int hi[4];
    m_d[0] = D0; m_d[1] = D1;
    m_h[0] = H0; m_h[1] = H1;
    m_entry[0] = 0; m_entry[1] = 0;
    for (int i = 0; i < 64; i++) begin
      pin_h[i] = 1'b0;
      bs_h[i] = 1'b0;
    end
    m_async_reset();
    hi[0] = 1; hi[1] = 3; hi[2] = 7; hi[3] = 2;

    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    // Power-up: reset for 5 cycles, then release with button idle.
    repeat (5) step(1'b0, 1'b1);
    chk("powerup_reset_out_held", ro0, 1);
    k = 0; pe_cnt = 0;
    do begin
      step(1'b0, 1'b0);
      k++;
      pe_cnt += pe0;
    end while (ro0 && k < 40);
    chk("powerup_release_edges", k - 1, 5);
    chk("powerup_press_event", pe_cnt, 0);
    repeat (3) step(1'b0, 1'b0);

    // Clean press held 20 cycles.
    rise = -1; pe_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (ro0 && rise < 0) rise = i;
      pe_cnt += pe0;
    end
    chk("press_latency", rise, 10);
    chk("press_event_count", pe_cnt, 1);
    chk("press_state", st0, S_PRESSED);

    // Release stretch.
    fall = -1;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      if (!ro0 && fall < 0) fall = i;
    end
    chk("release_latency", fall, 14);

    // Bounce rejection on dut0.
    bad = 0; pe_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      repeat (hi[p]) begin
        step(1'b1, 1'b0);
        bad += ro0; pe_cnt += pe0;
      end
      step(1'b0, 1'b0);
      bad += ro0; pe_cnt += pe0;
    end
    repeat (12) begin
      step(1'b0, 1'b0);
      bad += ro0; pe_cnt += pe0;
    end
    chk("bounce_reset_out", bad, 0);
    chk("bounce_press_event", pe_cnt, 0);

    // Press accepted during HOLD (dut1): press, 1-cycle release, press again.
    bad = 0; pe_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step((i == 4) ? 1'b0 : 1'b1, 1'b0);
      if (i >= 3) bad += (ro1 == 1'b0);
      pe_cnt += pe1;
    end
    chk("hold_press_reset_out_low", bad, 0);
    chk("hold_press_pulses", pe_cnt, 2);
    fall = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      if (!ro1 && fall < 0) fall = i;
    end
    chk("dut1_release_latency", fall, 6);

    // Asynchronous reset while pressed, button still held at release.
    repeat (20) step(1'b1, 1'b0);
    chk("pre_reset_state", st0, S_PRESSED);
    reset = 1'b1;
    #1;
    chk("async_reset_out", ro0, 1);
    chk("async_reset_state", st0, S_HOLD);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rise = -1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      if (pe0 && rise < 0) rise = i;
    end
    chk("redebounce_press_event", rise, 12);
    repeat (20) step(1'b0, 1'b0);

    // Randomised segments with occasional resets.
    for (int s = 0; s < 80; s++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 15) == 0) repeat ($urandom_range(1, 3)) step(lvl, 1'b1);
      repeat (len) step(lvl, 1'b0);
    end
    repeat (30) step(1'b0, 1'b0);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
